base_count_tracker: RTL

- Upstream stage of the scoreboard controller. Consumes one-cycle pitch/play event pulses and maintains the ball/strike/out count, base occupancy, and inning state.
- Drives runner_1st/2nd/3rd and ball_count_3, which the scoreboard samples on the same edge as a hit or ball event. Those outputs must therefore show pre-event state during the event cycle.
- Also reports the runs scored per play, for cross-checking the scoreboard.

---
 rtl/base_count_tracker_if.sv | 41 ++++
 rtl/base_count_tracker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/base_count_tracker_if.sv
// Event/status bundle between the pitch/play event source and base_count_tracker.
// master drives the one-cycle event pulses; slave returns the registered game state.
interface base_count_tracker_if #(
  parameter int INN_W = 4
);
  logic             ball;
  logic             strike;
  logic             foul;
  logic             out;
  logic             single;
  logic             double;
  logic             triple;
  logic             homerun;
  logic             runner_1st;
  logic             runner_2nd;
  logic             runner_3rd;
  logic [1:0]       ball_count;
  logic             ball_count_3;
  logic [1:0]       strike_count;
  logic [1:0]       out_count;
  logic [2:0]       runs;
  logic             run_valid;
  logic             side_change;
  logic [INN_W-1:0] inning;
  logic             bottom;
  logic             game_over;

  modport master (
    output ball, strike, foul, out, single, double, triple, homerun,
    input  runner_1st, runner_2nd, runner_3rd, ball_count, ball_count_3,
           strike_count, out_count, runs, run_valid, side_change,
           inning, bottom, game_over
  );

  modport slave (
    input  ball, strike, foul, out, single, double, triple, homerun,
    output runner_1st, runner_2nd, runner_3rd, ball_count, ball_count_3,
           strike_count, out_count, runs, run_valid, side_change,
           inning, bottom, game_over
  );
endinterface

// File: rtl/base_count_tracker.sv
// Ball/strike/out count, base occupancy and inning tracker. All outputs come from
// registers, so during an event cycle the scoreboard still sees the pre-event state.
module base_count_tracker #(
  parameter int MAX_INNINGS = 9,
  parameter int INN_W       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  base_count_tracker_if.slave bus
);

  typedef enum logic [3:0] {
    EV_NONE, EV_BALL, EV_SINGLE, EV_DOUBLE, EV_TRIPLE,
    EV_HOMERUN, EV_STRIKE, EV_FOUL, EV_OUT
  } event_e;

  typedef struct packed {
    logic             r1;
    logic             r2;
    logic             r3;
    logic [1:0]       balls;
    logic [1:0]       strikes;
    logic [1:0]       outs;
    logic [2:0]       runs;
    logic             run_valid;
    logic             side_change;
    logic [INN_W-1:0] inning;
    logic             bottom;
    logic             game_over;
  } state_t;

  state_t cur;
  state_t nxt;
  event_e ev;
  logic   record_out;

  // Only the highest-priority pulse of a cycle is acted on.
  always_comb begin
    if      (bus.ball)    ev = EV_BALL;
    else if (bus.single)  ev = EV_SINGLE;
    else if (bus.double)  ev = EV_DOUBLE;
    else if (bus.triple)  ev = EV_TRIPLE;
    else if (bus.homerun) ev = EV_HOMERUN;
    else if (bus.strike)  ev = EV_STRIKE;
    else if (bus.foul)    ev = EV_FOUL;
    else if (bus.out)     ev = EV_OUT;
    else                  ev = EV_NONE;
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
    nxt             = cur;
    nxt.runs        = '0;
    nxt.run_valid   = 1'b0;
    nxt.side_change = 1'b0;
    record_out      = 1'b0;

    if (!cur.game_over) begin
      case (ev)
        EV_BALL: begin
          if (cur.balls != 2'd3) begin
            nxt.balls = cur.balls + 2'd1;
          end else begin
            // Walk: runners advance only when forced from behind.
            nxt.r1      = 1'b1;
            nxt.r2      = cur.r2 | cur.r1;
            nxt.r3      = cur.r3 | (cur.r1 & cur.r2);
            nxt.runs    = {2'b00, cur.r1 & cur.r2 & cur.r3};
            nxt.balls   = 2'd0;
            nxt.strikes = 2'd0;
          end
        end
        EV_SINGLE: begin
          nxt.r3      = cur.r2;
          nxt.r2      = cur.r1;
          nxt.r1      = 1'b1;
          nxt.runs    = {2'b00, cur.r3};
          nxt.balls   = 2'd0;
          nxt.strikes = 2'd0;
        end
        EV_DOUBLE: begin
          nxt.r3      = cur.r1;
          nxt.r2      = 1'b1;
          nxt.r1      = 1'b0;
          nxt.runs    = 3'(cur.r2) + 3'(cur.r3);
          nxt.balls   = 2'd0;
          nxt.strikes = 2'd0;
        end
        EV_TRIPLE: begin
          nxt.r3      = 1'b1;
          nxt.r2      = 1'b0;
          nxt.r1      = 1'b0;
          nxt.runs    = 3'(cur.r1) + 3'(cur.r2) + 3'(cur.r3);
          nxt.balls   = 2'd0;
          nxt.strikes = 2'd0;
        end
        EV_HOMERUN: begin
          nxt.r3      = 1'b0;
          nxt.r2      = 1'b0;
          nxt.r1      = 1'b0;
          nxt.runs    = 3'd1 + 3'(cur.r1) + 3'(cur.r2) + 3'(cur.r3);
          nxt.balls   = 2'd0;
          nxt.strikes = 2'd0;
        end
        EV_STRIKE: begin
          if (cur.strikes != 2'd2) nxt.strikes = cur.strikes + 2'd1;
          else                     record_out  = 1'b1;
        end
        EV_FOUL: begin
          if (cur.strikes != 2'd2) nxt.strikes = cur.strikes + 2'd1;
        end
        EV_OUT:  record_out = 1'b1;
        default: ;
      endcase

      if (record_out) begin
        nxt.balls   = 2'd0;
        nxt.strikes = 2'd0;
        if (cur.outs != 2'd2) begin
          nxt.outs = cur.outs + 2'd1;
        end else begin
          nxt.outs        = 2'd0;
          nxt.r1          = 1'b0;
          nxt.r2          = 1'b0;
          nxt.r3          = 1'b0;
          nxt.side_change = 1'b1;
          if (!cur.bottom) begin
            nxt.bottom = 1'b1;
          end else if (cur.inning < INN_W'(MAX_INNINGS)) begin
            nxt.bottom = 1'b0;
            nxt.inning = cur.inning + INN_W'(1);
          end else begin
            nxt.game_over = 1'b1;
          end
        end
      end

      nxt.run_valid = (nxt.runs != 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      cur.inning <= INN_W'(1);
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      cur <= nxt;
    end
  end

  assign bus.runner_1st   = cur.r1;
  assign bus.runner_2nd   = cur.r2;
  assign bus.runner_3rd   = cur.r3;
  assign bus.ball_count   = cur.balls;
  assign bus.ball_count_3 = (cur.balls == 2'd3);
  assign bus.strike_count = cur.strikes;
  assign bus.out_count    = cur.outs;
  assign bus.runs         = cur.runs;
  assign bus.run_valid    = cur.run_valid;
  assign bus.side_change  = cur.side_change;
  assign bus.inning       = cur.inning;
  assign bus.bottom       = cur.bottom;
  assign bus.game_over    = cur.game_over;

endmodule
